// File: rtl/fft_frame_loader_if.sv
// Bus bundle between the sample stream source, the frame loader and the FFT core RAM write port.
// Master is the upstream source / core side; slave is the loader.
interface fft_frame_loader_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 3
);
  logic              s_valid;
  logic              s_ready;
  logic [DATA_W-1:0] s_real;
  logic [DATA_W-1:0] s_imag;
  logic              s_last;
  logic [DATA_W-1:0] real_in;
  logic [DATA_W-1:0] imag_in;
  logic [ADDR_W-1:0] addr_real;
  logic [ADDR_W-1:0] addr_imag;
  logic              wr_en_real;
  logic              wr_en_imag;

  modport master (
    output s_valid, s_real, s_imag, s_last,
    input  s_ready, real_in, imag_in, addr_real, addr_imag, wr_en_real, wr_en_imag
  );

  modport slave (
    input  s_valid, s_real, s_imag, s_last,
    output s_ready, real_in, imag_in, addr_real, addr_imag, wr_en_real, wr_en_imag
  );
endinterface

// File: rtl/fft_frame_loader.sv
// Converts a valid/ready complex sample stream into per-frame RAM writes for the FFT core,
// zero-padding short frames. Define FFT_LOADER_BITREV_EN to write in bit-reversed address order.
module fft_frame_loader #(
  parameter int DATA_W        = 12,
  parameter int N_POINTS      = 8,
  parameter int ADDR_W        = 3,
  parameter int SETTLE_CYCLES = 16
) (
  input  logic                clk,
  input  logic                reset,
  fft_frame_loader_if.slave   bus,
  output logic                busy,
  output logic                frame_done,
  output logic [7:0]          frame_count
);

  localparam logic [1:0] ST_LOAD   = 2'd0;
  localparam logic [1:0] ST_PAD    = 2'd1;
  localparam logic [1:0] ST_SETTLE = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  localparam int                CNT_W       = $clog2(SETTLE_CYCLES + 1);
  localparam logic [ADDR_W-1:0] LAST_IDX    = ADDR_W'(N_POINTS - 1);
  localparam logic [CNT_W-1:0]  SETTLE_LAST = CNT_W'(SETTLE_CYCLES - 1);

  logic [1:0]        state;
  logic [ADDR_W-1:0] idx;
  logic [CNT_W-1:0]  settle_cnt;
  logic [DATA_W-1:0] real_q;
  logic [DATA_W-1:0] imag_q;
  logic [ADDR_W-1:0] addr_q;
  logic              wr_q;
  logic              accept;

  function automatic logic [ADDR_W-1:0] map_addr(input logic [ADDR_W-1:0] i);
    logic [ADDR_W-1:0] r;
`ifdef FFT_LOADER_BITREV_EN
    for (int b = 0; b < ADDR_W; b++) r[b] = i[ADDR_W-1-b];
`else
    r = i;
`endif
    return r;
  endfunction

  // Ready is masked by reset so nothing can be accepted while reset is held.
  assign bus.s_ready   = (state == ST_LOAD) && !reset;
  assign accept        = bus.s_valid && bus.s_ready;
  assign bus.real_in   = real_q;
  assign bus.imag_in   = imag_q;
  assign bus.addr_real = addr_q;
  assign bus.addr_imag = addr_q;
  assign bus.wr_en_real = wr_q;
  assign bus.wr_en_imag = wr_q;
  assign busy          = (state != ST_LOAD);
  assign frame_done    = (state == ST_DONE);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= ST_LOAD;
      idx         <= '0;
      settle_cnt  <= '0;
      real_q      <= '0;
      imag_q      <= '0;
      addr_q      <= '0;
      wr_q        <= 1'b0;
      frame_count <= 8'd0;
    end else begin
      wr_q <= 1'b0;
      case (state)
        ST_LOAD: begin
          if (accept) begin
            real_q <= bus.s_real;
            imag_q <= bus.s_imag;
            addr_q <= map_addr(idx);
            wr_q   <= 1'b1;
            // The last slot always closes the frame, whatever s_last says.
            if (idx == LAST_IDX) begin
              state      <= ST_SETTLE;
              settle_cnt <= '0;
              idx        <= '0;
            end else begin
              idx <= idx + ADDR_W'(1);
              if (bus.s_last) state <= ST_PAD;
            end
          end
        end
        ST_PAD: begin
          real_q <= '0;
          imag_q <= '0;
          addr_q <= map_addr(idx);
          wr_q   <= 1'b1;
          if (idx == LAST_IDX) begin
            state      <= ST_SETTLE;
            settle_cnt <= '0;
            idx        <= '0;
          end else begin
            idx <= idx + ADDR_W'(1);
          end
        end
        ST_SETTLE: begin
          if (settle_cnt == SETTLE_LAST) state <= ST_DONE;
          else settle_cnt <= settle_cnt + CNT_W'(1);
        end
        ST_DONE: begin
          state       <= ST_LOAD;
          idx         <= '0;
          frame_count <= frame_count + 8'd1;
        end
        default: state <= ST_LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_fft_frame_loader.sv
// Directed bench for fft_frame_loader: logs every write, accept and frame_done by cycle,
// then checks them against hand-computed frame layouts and timings.
module tb_fft_frame_loader;
  localparam int DATA_W = 12;
  localparam int ADDR_W = 3;
  localparam int N      = 8;
  localparam int SETTLE = 16;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;

  typedef struct {
    int                cyc;
    logic [ADDR_W-1:0] addr;
    logic [ADDR_W-1:0] addr_i;
    logic [DATA_W-1:0] re;
    logic [DATA_W-1:0] im;
    logic              wr_i;
  } wr_t;

  wr_t wr_log[$];
  int  acc_log[$];
  int  done_log[$];

  fft_frame_loader_if #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) bus ();

  fft_frame_loader #(
    .DATA_W(DATA_W), .N_POINTS(N), .ADDR_W(ADDR_W), .SETTLE_CYCLES(SETTLE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are observed mid-cycle, well away from the rising edge.
  always @(negedge clk) begin
    if (!reset) begin
      if (bus.wr_en_real)
        wr_log.push_back('{cyc, bus.addr_real, bus.addr_imag, bus.real_in, bus.imag_in, bus.wr_en_imag});
      if (bus.s_valid && bus.s_ready) acc_log.push_back(cyc);
      if (frame_done) done_log.push_back(cyc);
    end
  end

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, required completion");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [ADDR_W-1:0] exp_addr(input int i);
`ifdef FFT_LOADER_BITREV_EN
    logic [ADDR_W-1:0] br [8] = '{3'd0, 3'd4, 3'd2, 3'd6, 3'd1, 3'd5, 3'd3, 3'd7};
    return br[i];
`else
    return ADDR_W'(i);
`endif
  endfunction

  task automatic clear_logs();
    wr_log.delete();
    acc_log.delete();
    done_log.delete();
  endtask

  task automatic applyStimulus(input int val, input bit last);
    int g = 0;
    bus.s_valid = 1'b1;
    bus.s_real  = DATA_W'(val);
    bus.s_imag  = DATA_W'(-val);
    bus.s_last  = last;
    @(negedge clk);
    while (!bus.s_ready && g < 200) begin
      @(negedge clk);
      g++;
    end
    checkOutput("accept_wait", 32'(bus.s_ready), 1);
    @(posedge clk);
    #1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
  endtask

  task automatic send_frame(input int base, input int n, input bit short_last, input bit gap);
    for (int i = 0; i < n; i++) begin
      applyStimulus(base + i, short_last && (i == n - 1));
      if (gap) begin
        @(posedge clk);
        #1;
      end
    end
  endtask

  task automatic wait_frames(input int n);
    int g = 0;
    while (done_log.size() < n && g < 400) begin
      @(posedge clk);
      g++;
    end
    #1;
    checkOutput("frame_done_seen", 32'(done_log.size() >= n), 1);
  endtask

  task automatic do_reset();
    reset       = 1'b1;
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_real  = '0;
    bus.s_imag  = '0;
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_s_ready", 32'(bus.s_ready), 0);
    checkOutput("rst_wr_en", 32'(bus.wr_en_real), 0);
    checkOutput("rst_busy", 32'(busy), 0);
    checkOutput("rst_frame_done", 32'(frame_done), 0);
    checkOutput("rst_frame_count", 32'(frame_count), 0);
    checkOutput("rst_addr", 32'(bus.addr_real), 0);
    checkOutput("rst_real", 32'(bus.real_in), 0);
    reset = 1'b0;
    @(posedge clk);
    #1;
    clear_logs();
  endtask

  // Checks one logged frame: n_data samples base.. then zero pads, one cycle after each accept.
  task automatic check_frame(input string t, input int wf, input int af, input int n_data,
                             input int base, input bit cont);
    wr_t e;
    logic [DATA_W-1:0] er, ei;
    bit ok = 1;
    if (wr_log.size() < wf + N) begin
      checkOutput({t, "_wr_count"}, wr_log.size(), wf + N);
      ok = 0;
    end
    if (acc_log.size() < af + n_data) begin
      checkOutput({t, "_acc_count"}, acc_log.size(), af + n_data);
      ok = 0;
    end
    if (!ok) return;
    for (int i = 0; i < N; i++) begin
      e  = wr_log[wf + i];
      er = (i < n_data) ? DATA_W'(base + i) : '0;
      ei = (i < n_data) ? DATA_W'(-(base + i)) : '0;
      checkOutput($sformatf("%s_addr%0d", t, i), e.addr, exp_addr(i));
      checkOutput($sformatf("%s_addr_imag%0d", t, i), e.addr_i, exp_addr(i));
      checkOutput($sformatf("%s_wr_imag%0d", t, i), e.wr_i, 1);
      checkOutput($sformatf("%s_real%0d", t, i), e.re, er);
      checkOutput($sformatf("%s_imag%0d", t, i), e.im, ei);
      if (i < n_data)
        checkOutput($sformatf("%s_latency%0d", t, i), e.cyc, acc_log[af + i] + 1);
      if (i > 0 && (cont || i >= n_data))
        checkOutput($sformatf("%s_consec%0d", t, i), e.cyc, wr_log[wf + i - 1].cyc + 1);
    end
  endtask

  initial begin
    bus.s_valid = 1'b0;
    bus.s_last  = 1'b0;
    bus.s_real  = '0;
    bus.s_imag  = '0;
    do_reset();

    // Continuous full frame, timing of settle window and ready return.
    send_frame(1, 8, 1'b0, 1'b0);
    wait_frames(1);
    check_frame("t1", 0, 0, 8, 1, 1'b1);
    if (done_log.size() > 0 && wr_log.size() >= N)
      checkOutput("t1_done_cycle", done_log[0], wr_log[N-1].cyc + SETTLE);
    checkOutput("t1_ready_after", 32'(bus.s_ready), 1);
    checkOutput("t1_busy_after", 32'(busy), 0);
    checkOutput("t1_frame_count", 32'(frame_count), 1);

    // Valid toggling: one write per accept, no duplicates.
    clear_logs();
    send_frame(101, 8, 1'b0, 1'b1);
    wait_frames(1);
    check_frame("t2", 0, 0, 8, 101, 1'b0);
    checkOutput("t2_wr_total", wr_log.size(), 8);
    checkOutput("t2_acc_total", acc_log.size(), 8);
    checkOutput("t2_frame_count", 32'(frame_count), 2);

    // Short frame padded, next sample held through PAD and SETTLE.
    clear_logs();
    send_frame(1, 3, 1'b1, 1'b0);
    send_frame(50, 8, 1'b0, 1'b0);
    wait_frames(2);
    check_frame("t3a", 0, 0, 3, 1, 1'b1);
    if (done_log.size() > 0 && wr_log.size() >= N && acc_log.size() > 3) begin
      checkOutput("t3_done_cycle", done_log[0], wr_log[N-1].cyc + SETTLE);
      checkOutput("t3_held_accept", acc_log[3], done_log[0] + 1);
    end
    check_frame("t3b", 8, 3, 8, 50, 1'b1);
    checkOutput("t3_acc_total", acc_log.size(), 11);
    checkOutput("t3_frame_count", 32'(frame_count), 4);

    // Valid held through SETTLE after a full frame.
    clear_logs();
    send_frame(1, 8, 1'b0, 1'b0);
    send_frame(77, 8, 1'b0, 1'b0);
    wait_frames(2);
    if (done_log.size() > 0 && acc_log.size() > 8)
      checkOutput("t4_held_accept", acc_log[8], done_log[0] + 1);
    check_frame("t4b", 8, 8, 8, 77, 1'b1);
    checkOutput("t4_wr_total", wr_log.size(), 16);
    checkOutput("t4_frame_count", 32'(frame_count), 6);

    // Reset mid-frame discards everything in flight.
    do_reset();
    send_frame(1, 5, 1'b0, 1'b0);
    checkOutput("t5_wr_before_rst", 32'(bus.wr_en_real), 1);
    reset = 1'b1;
    #1;
    checkOutput("t5_rst_wr_en", 32'(bus.wr_en_real), 0);
    checkOutput("t5_rst_s_ready", 32'(bus.s_ready), 0);
    checkOutput("t5_rst_addr", 32'(bus.addr_real), 0);
    checkOutput("t5_rst_real", 32'(bus.real_in), 0);
    checkOutput("t5_rst_busy", 32'(busy), 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    clear_logs();
    repeat (40) @(posedge clk);
    #1;
    checkOutput("t5_no_done", done_log.size(), 0);
    checkOutput("t5_no_write", wr_log.size(), 0);
    checkOutput("t5_frame_count", 32'(frame_count), 0);
    send_frame(20, 8, 1'b0, 1'b0);
    wait_frames(1);
    check_frame("t5", 0, 0, 8, 20, 1'b1);
    checkOutput("t5_frame_count_after", 32'(frame_count), 1);

    // 256 frames wrap the frame counter.
    do_reset();
    for (int f = 0; f < 256; f++) begin
      clear_logs();
      send_frame(f, 8, 1'b0, 1'b0);
      wait_frames(1);
      if (f == 254) checkOutput("t7_count_255", 32'(frame_count), 255);
    end
    checkOutput("t7_count_wrap", 32'(frame_count), 0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
